register_skid_slice: RTL and testbench
======================================

REGISTER_SKID_SLICE -- requirements
Module: register_skid_slice

Interface
REQ-001 Parameter WIDTH, default 8, data payload width in bits.
REQ-002 Parameter COUNT_W, default 16, width of the output-transfer counter.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 flush  input  1  synchronous clear of buffered data.
REQ-006 s_valid  input  1  upstream data valid.
REQ-007 s_data  input  WIDTH  upstream data.
REQ-008 s_ready  output  1  slice can accept; registered.
REQ-009 m_valid  output  1  downstream data valid; registered.
REQ-010 m_data  output  WIDTH  downstream data; registered.
REQ-011 m_ready  input  1  downstream accepts.
REQ-012 occupancy  output  2  number of held entries (0..2).
REQ-013 xfer_count  output  COUNT_W  count of completed output transfers.

Function
REQ-014 accept = s_valid & s_ready; pop = m_valid & m_ready, both evaluated in the same cycle.
REQ-015 Storage: main register (drives m_data) plus one skid register; no other data storage.
REQ-016 FSM states: EMPTY (occupancy 0), BUSY (1), FULL (2); the state fully determines m_valid, s_ready and occupancy.
REQ-017 EMPTY: on accept, main <= s_data and the state moves to BUSY; otherwise the state is held.
REQ-018 BUSY, accept & !pop: skid <= s_data and the state moves to FULL.
REQ-019 BUSY, accept & pop: main <= s_data and the state stays BUSY.
REQ-020 BUSY, !accept & pop: the state moves to EMPTY; main is retained and is don't-care.
REQ-021 BUSY, no accept and no pop: everything is held.
REQ-022 FULL: s_ready = 0, so there is no accept; on pop, main <= skid and the state moves to BUSY; otherwise everything is held.
REQ-023 m_valid = 1 in BUSY and FULL, 0 in EMPTY; s_ready = 1 in EMPTY and BUSY, 0 in FULL.
REQ-024 There is no combinational path from any input to any output; s_ready and m_valid come from flops.
REQ-025 Latency: data accepted in cycle N is presented on m_data/m_valid in cycle N+1 if the slice was EMPTY or popped in cycle N.
REQ-026 Ordering is strictly FIFO; no beat is dropped or duplicated except under flush/reset.
REQ-027 While m_valid = 1 and m_ready = 0, m_data is held stable.
REQ-028 xfer_count increments by 1 on each pop and wraps from 2^COUNT_W-1 to 0.
REQ-029 flush = 1: the next state is EMPTY regardless of accept/pop.
REQ-030 flush = 1: an accept in the same cycle is discarded.
REQ-031 flush = 1: a pop in the same cycle still counts in xfer_count.
REQ-032 flush does not clear xfer_count.

Reset
REQ-033 reset takes priority over flush and all transfers.
REQ-034 While reset = 1: state EMPTY, m_valid = 0, s_ready = 0, occupancy = 0, m_data = 0, skid = 0, xfer_count = 0.
REQ-035 In the first cycle after reset deasserts, s_ready = 1.
REQ-036 A reset asserted mid-operation discards all held entries with no output transfer.

Verification
REQ-037 Reset, then s_valid = 1 with s_data = 0x11 and m_ready = 1 -> next cycle m_valid = 1, m_data = 0x11, occupancy = 1; xfer_count = 1 after the pop.
REQ-038 m_ready = 0, push 0xA1 then 0xA2 -> occupancy = 2, s_ready = 0, m_data = 0xA1 held; raise m_ready -> 0xA1 then 0xA2 are output, then m_valid = 0.
REQ-039 Continuous s_valid with m_ready = 1 and data 0x00..0xFF -> one beat per cycle, in order, s_ready never drops, xfer_count = 256.
REQ-040 FULL state plus flush = 1 together with m_ready = 1 -> next cycle EMPTY, m_valid = 0, xfer_count +1; the skid entry is never output.
REQ-041 Reset asserted while FULL -> all outputs reach the REQ-034 values the following cycle; s_ready = 1 in the first cycle after reset deasserts.
REQ-042 COUNT_W = 4, 17 pops -> xfer_count = 1 (wraps once).

Source files
------------

// File: rtl/register_skid_slice.sv
// Two-entry valid/ready register slice: main register drives m_data, skid register
// absorbs the beat that arrives while downstream stalls. All outputs come from flops.
module register_skid_slice #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               s_valid,
    input  logic [WIDTH-1:0]   s_data,
    output logic               s_ready,
    output logic               m_valid,
    output logic [WIDTH-1:0]   m_data,
    input  logic               m_ready,
    output logic [1:0]         occupancy,
    output logic [COUNT_W-1:0] xfer_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   main_q, main_d;
    logic [WIDTH-1:0]   skid_q, skid_d;
    logic               m_valid_q, m_valid_d;
    logic               s_ready_q, s_ready_d;
    logic [1:0]         occ_q, occ_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;

    logic accept;
    logic pop;

    assign accept = s_valid & s_ready_q;
    assign pop    = m_valid_q & m_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q;

        if (pop) begin
            cnt_d = cnt_q + COUNT_W'(1);
        end

        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_d  = s_data;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (accept && !pop) begin
                    skid_d  = s_data;
                    state_d = FULL;
                end else if (accept && pop) begin
                    main_d  = s_data;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    main_d  = skid_q;
                    state_d = BUSY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        // Flush drops held and incoming beats, but a pop this cycle still happened.
        if (flush) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end

        m_valid_d = (state_d != EMPTY);
        s_ready_d = (state_d != FULL);

        unique case (state_d)
            BUSY:    occ_d = 2'd1;
            FULL:    occ_d = 2'd2;
            default: occ_d = 2'd0;
        endcase
    end

    // s_ready is held low throughout reset and rises on the first free-running edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b0;
            occ_q     <= 2'd0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            m_valid_q <= m_valid_d;
            s_ready_q <= s_ready_d;
            occ_q     <= occ_d;
            cnt_q     <= cnt_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign m_valid    = m_valid_q;
    assign m_data     = main_q;
    assign occupancy  = occ_q;
    assign xfer_count = cnt_q;

endmodule

// File: tb/tb_register_skid_slice.sv
// Bench for register_skid_slice: directed scenarios plus random traffic,
// checked every cycle against a queue-based FIFO model.
module tb_register_skid_slice;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        m_ready;
    logic        s_ready, m_valid;
    logic [7:0]  m_data;
    logic [1:0]  occupancy;
    logic [15:0] xfer_count;

    logic        s_ready4, m_valid4;
    logic [7:0]  m_data4;
    logic [1:0]  occupancy4;
    logic [3:0]  xfer_count4;

    register_skid_slice #(.WIDTH(8), .COUNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .occupancy(occupancy), .xfer_count(xfer_count)
    );

    register_skid_slice #(.WIDTH(8), .COUNT_W(4)) dut_w4 (
        .clk(clk), .reset(reset), .flush(flush),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready4),
        .m_valid(m_valid4), .m_data(m_data4), .m_ready(m_ready),
        .occupancy(occupancy4), .xfer_count(xfer_count4)
    );

    always #5 clk = ~clk;

    int         passed = 0;
    int         total  = 0;
    logic [7:0] q[$];
    int         cnt    = 0;
    logic       mdl_rdy = 1'b0;
    logic       data_zero = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic check_outputs();
        chk("m_valid", 32'(m_valid), 32'(q.size() != 0));
        chk("s_ready", 32'(s_ready), 32'(mdl_rdy));
        chk("occupancy", 32'(occupancy), 32'(q.size()));
        chk("xfer_count", 32'(xfer_count), 32'(cnt % 65536));
        chk("xfer_count_w4", 32'(xfer_count4), 32'(cnt % 16));
        chk("w4_m_valid", 32'(m_valid4), 32'(q.size() != 0));
        if (q.size() != 0)
            chk("m_data", 32'(m_data), 32'(q[0]));
        else if (data_zero)
            chk("m_data_reset", 32'(m_data), 32'h0);
    endtask

    // One clock: drive inputs, predict from the model, advance model, compare.
    task automatic cycle(input logic sv, input logic [7:0] sd, input logic mr,
                         input logic fl, input logic rs);
        logic acc, pop;
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        flush   = fl;
        reset   = rs;
        acc = sv && mdl_rdy;
        pop = (q.size() != 0) && mr;
        @(posedge clk);
        #1;
        if (rs) begin
            q.delete();
            cnt       = 0;
            mdl_rdy   = 1'b0;
            data_zero = 1'b1;
        end else begin
            if (pop) begin
                void'(q.pop_front());
                cnt++;
            end
            if (fl) q.delete();
            else if (acc) begin
                q.push_back(sd);
                data_zero = 1'b0;
            end
            mdl_rdy = (q.size() < 2);
        end
        check_outputs();
    endtask

    task automatic do_reset();
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int d;
        int n;
        do_reset();
        chk("s_ready_after_reset", 32'(s_ready), 32'h1);

        // Single beat, one-cycle latency
        cycle(1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
        chk("first_beat", 32'(m_data), 32'h11);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("first_count", 32'(xfer_count), 32'h1);

        // Stall fills both entries, then drains in order
        cycle(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0);
        chk("full_occ", 32'(occupancy), 32'h2);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        chk("full_hold", 32'(m_data), 32'hA1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("drain_second", 32'(m_data), 32'hA2);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("drain_empty", 32'(m_valid), 32'h0);

        // Streaming 0x00..0xFF at full rate
        do_reset();
        d = 0;
        n = 0;
        while (cnt < 256 && n < 400) begin
            logic go;
            go = mdl_rdy && (d < 256);
            cycle(d < 256, 8'(d), 1'b1, 1'b0, 1'b0);
            if (go) d++;
            n++;
        end
        chk("stream_count", 32'(xfer_count), 32'd256);
        chk("stream_cycles", 32'(n), 32'd257);

        // Flush while full with a simultaneous pop
        cycle(1'b1, 8'hB1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hB2, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("flush_empty", 32'(m_valid), 32'h0);
        chk("flush_count", 32'(xfer_count), 32'd257);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Reset while full
        cycle(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hC2, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hC3, 1'b1, 1'b0, 1'b1);
        chk("rst_full_sready", 32'(s_ready), 32'h0);
        chk("rst_full_mdata", 32'(m_data), 32'h0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("rst_release_sready", 32'(s_ready), 32'h1);

        // 17 pops on the 4-bit counter wraps once
        do_reset();
        d = 0;
        n = 0;
        while (cnt < 17 && n < 40) begin
            logic go;
            go = mdl_rdy && (d < 17);
            cycle(d < 17, 8'(d + 8'h40), 1'b1, 1'b0, 1'b0);
            if (go) d++;
            n++;
        end
        chk("w4_wrap", 32'(xfer_count4), 32'h1);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 99) == 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
